// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX stage: control-bit layout, stall FSM
// encoding and a small decode helper for the control byte.
package id_ex_stage_reg_pkg;

    // Control byte layout {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,Branch,ALUOp}
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 2;

    // Stall FSM: RUN lets the register advance, HOLD freezes it
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Bit position of a control field once the ALUOp width is known
    function automatic int ctrl_bit(input int field, input int aluop_w);
        return field - CTRL_ALUOP_W + aluop_w;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination is a
// source of the instruction currently in ID.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              luh
);

    logic rd_nonzero_s;
    logic rd_match_s;

    // x0 is never a real producer, so a load to x0 cannot cause a hazard
    always_comb begin
        rd_nonzero_s = (ex_rd != '0);
        rd_match_s   = (ex_rd == id_rs1) | (ex_rd == id_rs2);
        luh          = id_valid & ex_valid & ex_mem_read & rd_nonzero_s & rd_match_s;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and data-cache
// stall hold. Optional performance counters are built when
// ID_EX_PERF_CNT_EN is defined; otherwise the counter ports read 0.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 10,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mem_stall_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [DATA_W-1:0]  id_pc_i,
    input  logic [DATA_W-1:0]  id_rs1_data_i,
    input  logic [DATA_W-1:0]  id_rs2_data_i,
    input  logic [DATA_W-1:0]  id_imm_i,
    input  logic [REG_AW-1:0]  id_rs1_i,
    input  logic [REG_AW-1:0]  id_rs2_i,
    input  logic [REG_AW-1:0]  id_rd_i,
    input  logic [ALUOP_W+5:0] id_ctrl_i,
    input  logic [FUNCT_W-1:0] id_funct_i,
    output logic               ex_valid_o,
    output logic [DATA_W-1:0]  ex_pc_o,
    output logic [DATA_W-1:0]  ex_rs1_data_o,
    output logic [DATA_W-1:0]  ex_rs2_data_o,
    output logic [DATA_W-1:0]  ex_imm_o,
    output logic [REG_AW-1:0]  ex_rs1_o,
    output logic [REG_AW-1:0]  ex_rs2_o,
    output logic [REG_AW-1:0]  ex_rd_o,
    output logic [ALUOP_W+5:0] ex_ctrl_o,
    output logic [FUNCT_W-1:0] ex_funct_o,
    output logic               luh_stall_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   hold_cnt_o
);

    localparam int MEMREAD_BIT = ctrl_bit(CTRL_MEMREAD, ALUOP_W);

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  rs1_data;
        logic [DATA_W-1:0]  rs2_data;
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W+5:0] ctrl;
        logic [FUNCT_W-1:0] funct;
    } stage_t;

    state_e state_r;
    state_e state_nx_s;
    stage_t ex_r;
    stage_t ex_nx_s;
    stage_t id_stage_s;
    logic   luh_s;
    logic   load_en_s;
    logic   bubble_s;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_luh (
        .id_valid    (id_valid_i),
        .ex_valid    (ex_r.valid),
        .ex_mem_read (ex_r.ctrl[MEMREAD_BIT]),
        .ex_rd       (ex_r.rd),
        .id_rs1      (id_rs1_i),
        .id_rs2      (id_rs2_i),
        .luh         (luh_s)
    );

    // Stall FSM next state: follow the data-cache busy flag
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_i) state_nx_s = ST_HOLD;
                else             state_nx_s = ST_RUN;
            end
            ST_HOLD: begin
                if (!mem_stall_i) state_nx_s = ST_RUN;
                else              state_nx_s = ST_HOLD;
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Next register contents: hold while stalled, bubble on flush/load-use, else load ID
    always_comb begin
        id_stage_s          = '0;
        id_stage_s.valid    = id_valid_i;
        id_stage_s.pc       = id_pc_i;
        id_stage_s.rs1_data = id_rs1_data_i;
        id_stage_s.rs2_data = id_rs2_data_i;
        id_stage_s.imm      = id_imm_i;
        id_stage_s.rs1      = id_rs1_i;
        id_stage_s.rs2      = id_rs2_i;
        id_stage_s.rd       = id_rd_i;
        id_stage_s.ctrl     = id_ctrl_i;
        id_stage_s.funct    = id_funct_i;
        load_en_s           = (state_nx_s == ST_RUN);
        bubble_s            = flush_i | luh_s;
        ex_nx_s             = ex_r;
        if (load_en_s) begin
            if (bubble_s) ex_nx_s = '0;
            else          ex_nx_s = id_stage_s;
        end else begin
            ex_nx_s = ex_r;
        end
    end

    // Pipeline register and FSM state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_r    <= '0;
            state_r <= ST_RUN;
        end else begin
            ex_r    <= ex_nx_s;
            state_r <= state_nx_s;
        end
    end

    // IF/ID is already frozen by the global stall, so no separate load-use stall then
    always_comb begin
        luh_stall_o = luh_s & ~mem_stall_i;
    end

    assign ex_valid_o    = ex_r.valid;
    assign ex_pc_o       = ex_r.pc;
    assign ex_rs1_data_o = ex_r.rs1_data;
    assign ex_rs2_data_o = ex_r.rs2_data;
    assign ex_imm_o      = ex_r.imm;
    assign ex_rs1_o      = ex_r.rs1;
    assign ex_rs2_o      = ex_r.rs2;
    assign ex_rd_o       = ex_r.rd;
    assign ex_ctrl_o     = ex_r.ctrl;
    assign ex_funct_o    = ex_r.funct;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] hold_cnt_r;

    // Wrapping counts of bubbles loaded and of stalled edges
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_r <= '0;
            hold_cnt_r   <= '0;
        end else begin
            if (load_en_s && bubble_s) bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
            if (state_nx_s == ST_HOLD) hold_cnt_r   <= hold_cnt_r + CNT_W'(1);
        end
    end

    assign bubble_cnt_o = bubble_cnt_r;
    assign hold_cnt_o   = hold_cnt_r;
`else
    assign bubble_cnt_o = '0;
    assign hold_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, load-use bubble, x0 load,
// cache stall hold, flush+load-use, and flush during stall.
module tb_id_ex_stage_reg;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [7:0] CTRL_LW  = 8'hE8; // RegWrite,MemtoReg,MemRead,ALUSrc
    localparam logic [7:0] CTRL_ADD = 8'h82; // RegWrite, ALUOp=10

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_stall_i;
    logic        flush_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [7:0]  id_ctrl_i;
    logic [9:0]  id_funct_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [7:0]  ex_ctrl_o;
    logic [9:0]  ex_funct_o;
    logic        luh_stall_o;
    logic [31:0] bubble_cnt_o, hold_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk_i(clk), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i),
        .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_ctrl_i(id_ctrl_i),
        .id_funct_i(id_funct_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o), .ex_funct_o(ex_funct_o),
        .luh_stall_o(luh_stall_o), .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
        id_valid_i    = v;
        id_pc_i       = pc;
        id_rs1_data_i = pc + 32'h0000_1000;
        id_rs2_data_i = pc + 32'h0000_2000;
        id_imm_i      = pc + 32'h0000_3000;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_rd_i       = rd;
        id_ctrl_i     = ctrl;
        id_funct_i    = {rs1, rd};
        #1;
    endtask

    initial begin
        rst_i       = 1'b0;
        mem_stall_i = 1'b0;
        flush_i     = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        #2;
        check("rst_valid",  64'(ex_valid_o), 64'd0);
        check("rst_pc",     64'(ex_pc_o), 64'd0);
        check("rst_luh",    64'(luh_stall_o), 64'd0);
        check("rst_bcnt",   64'(bubble_cnt_o), 64'd0);
        check("rst_hcnt",   64'(hold_cnt_o), 64'd0);
        #5 rst_i = 1'b1;

        // Load-use: lw x5 then add x6,x5,x1
        set_id(1'b1, 32'h10, 5'd2, 5'd0, 5'd5, CTRL_LW);
        step();
        check("lw_rd",      64'(ex_rd_o), 64'd5);
        check("lw_valid",   64'(ex_valid_o), 64'd1);
        check("lw_imm",     64'(ex_imm_o), 64'h3010);
        set_id(1'b1, 32'h14, 5'd5, 5'd1, 5'd6, CTRL_ADD);
        check("luh_assert", 64'(luh_stall_o), 64'd1);
        step();
        check("bub_valid",  64'(ex_valid_o), 64'd0);
        check("bub_ctrl",   64'(ex_ctrl_o), 64'd0);
        check("bub_rd",     64'(ex_rd_o), 64'd0);
        check("bub_pc",     64'(ex_pc_o), 64'd0);
        check("luh_clear",  64'(luh_stall_o), 64'd0);
        check("bcnt_1",     64'(bubble_cnt_o), PERF ? 64'd1 : 64'd0);
        step();
        check("add_rs1",    64'(ex_rs1_o), 64'd5);
        check("add_rd",     64'(ex_rd_o), 64'd6);
        check("add_pc",     64'(ex_pc_o), 64'h14);
        check("add_funct",  64'(ex_funct_o), 64'h0A6);

        // Load to x0 never stalls
        set_id(1'b1, 32'h18, 5'd2, 5'd0, 5'd0, CTRL_LW);
        step();
        set_id(1'b1, 32'h1C, 5'd0, 5'd0, 5'd7, CTRL_ADD);
        check("x0_luh",     64'(luh_stall_o), 64'd0);
        step();
        check("x0_valid",   64'(ex_valid_o), 64'd1);
        check("x0_pc",      64'(ex_pc_o), 64'h1C);

        // Cache stall: load at 0x40 held while ID changes, luh suppressed
        set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, CTRL_LW);
        step();
        check("st_pc0",     64'(ex_pc_o), 64'h40);
        mem_stall_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_id(1'b1, 32'h40 + 32'(4 * i), 5'd3, 5'd2, 5'd9, CTRL_ADD);
            check("st_luh",  64'(luh_stall_o), 64'd0);
            step();
            check("st_pc",   64'(ex_pc_o), 64'h40);
            check("st_rd",   64'(ex_rd_o), 64'd3);
        end
        check("hcnt_3",     64'(hold_cnt_o), PERF ? 64'd3 : 64'd0);
        mem_stall_i = 1'b0;
        set_id(1'b1, 32'h50, 5'd8, 5'd9, 5'd4, CTRL_LW);
        step();
        check("rel_pc",     64'(ex_pc_o), 64'h50);
        check("rel_valid",  64'(ex_valid_o), 64'd1);

        // Flush and load-use together: one bubble, counted once
        flush_i = 1'b1;
        set_id(1'b1, 32'h54, 5'd4, 5'd1, 5'd10, CTRL_ADD);
        check("fl_luh",     64'(luh_stall_o), 64'd1);
        step();
        flush_i = 1'b0;
        check("fl_valid",   64'(ex_valid_o), 64'd0);
        check("bcnt_2",     64'(bubble_cnt_o), PERF ? 64'd2 : 64'd0);
        set_id(1'b1, 32'h60, 5'd1, 5'd2, 5'd5, CTRL_ADD);
        step();
        check("fl_next_pc", 64'(ex_pc_o), 64'h60);
        check("bcnt_keep",  64'(bubble_cnt_o), PERF ? 64'd2 : 64'd0);

        // Flush while stalled is ignored
        mem_stall_i = 1'b1;
        flush_i     = 1'b1;
        set_id(1'b1, 32'h70, 5'd1, 5'd2, 5'd11, CTRL_ADD);
        step();
        step();
        check("sf_pc",      64'(ex_pc_o), 64'h60);
        check("sf_valid",   64'(ex_valid_o), 64'd1);
        check("sf_bcnt",    64'(bubble_cnt_o), PERF ? 64'd2 : 64'd0);
        mem_stall_i = 1'b0;
        flush_i     = 1'b0;
        set_id(1'b1, 32'h74, 5'd1, 5'd2, 5'd12, CTRL_ADD);
        step();
        check("sf_rel_pc",  64'(ex_pc_o), 64'h74);
        check("hcnt_5",     64'(hold_cnt_o), PERF ? 64'd5 : 64'd0);

        // Asynchronous reset mid-cycle while a load to x5 sits in EX
        set_id(1'b1, 32'h80, 5'd1, 5'd2, 5'd5, CTRL_LW);
        step();
        check("pre_rd",     64'(ex_rd_o), 64'd5);
        set_id(1'b1, 32'h84, 5'd5, 5'd2, 5'd6, CTRL_ADD);
        check("pre_luh",    64'(luh_stall_o), 64'd1);
        #1 rst_i = 1'b0;
        #1;
        check("ar_valid",   64'(ex_valid_o), 64'd0);
        check("ar_ctrl",    64'(ex_ctrl_o), 64'd0);
        check("ar_rd",      64'(ex_rd_o), 64'd0);
        check("ar_luh",     64'(luh_stall_o), 64'd0);
        check("ar_hcnt",    64'(hold_cnt_o), 64'd0);
        #1 rst_i = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
